i2c_data_path_burst: RTL and testbench
======================================

# i2c_data_path_burst

Parametrised successor to the single-byte I2C data path. It serialises address and data frames of `DATA_W` bits MSB-first onto SDA and deserialises read frames. It buffers bursts in TX/RX FIFOs, samples the bus ACK and detects arbitration loss. It sits between the I2C master control FSM, which supplies the phase command, and the SCL generator, which supplies the SCL phase counter.

## Interface
Parameters:
- `DATA_W`, 8: bits per address/data frame.
- `FIFO_DEPTH`, 4: entries in each of the TX and RX FIFOs; power of two, ≥ 2.
- `PRESC_W`, 8: width of `prescaler_i`.

Ports:
- `i2c_core_clock_i` in 1: core clock.
- `reset_bit_i` in 1: reset, asynchronous, active-low.
- `prescaler_i` in PRESC_W: SCL half-period P in core clocks; legal P ≥ 4.
- `counter_detect_edge_i` in PRESC_W+1: SCL phase, 0..2P-1. SCL is low on 0..P-1 and high on P..2P-1.
- `cmd_i` in 4: phase code IDLE/START/ADDR/WRITE/READ/WACK/RACK/STOP/RSTART.
- `sda_i` in 1: synchronised bus SDA.
- `addr_rw_i` in DATA_W: address byte, R/W in bit 0.
- `ack_bit_i` in 1: bit driven in WACK (0 = ACK).
- `tx_data_i` in DATA_W, `tx_valid_i` in 1, `tx_ready_o` out 1: TX push, valid/ready.
- `rx_data_o` out DATA_W, `rx_valid_o` out 1, `rx_ready_i` in 1: RX pop, valid/ready, first-word fall-through.
- `sda_o` out 1: SDA drive value (1 = release).
- `bit_cnt_o` out $clog2(DATA_W+1): bits remaining in the current frame.
- `frame_done_o` out 1: one-cycle pulse after the last bit of a frame is sampled.
- `ack_rcvd_o` out 1, `ack_valid_o` out 1: sampled ACK and its one-cycle strobe.
- `arb_lost_o` out 1: sticky arbitration-loss flag.
- `tx_underrun_o`, `rx_overflow_o` out 1: one-cycle error pulses.

## Operation
- Phase points:
  - Drive point D is phase 1.
  - Sample point S is phase P + P/2 (integer divide).
  - Condition point C is also P + P/2, used only for START/STOP/RSTART.
- Frame entry: `cmd_i` differs from its registered copy and the new value is ADDR, WRITE or READ. On entry, `bit_cnt` ← DATA_W and the shift register is loaded:
  - ADDR: loaded from `addr_rw_i`.
  - WRITE: loaded from the TX FIFO head, which is popped. If the TX FIFO is empty, the register is loaded all-ones and `tx_underrun_o` pulses.
  - READ: the register is cleared.
- At each D while `bit_cnt` > 0:
  - ADDR/WRITE: `sda_o` ← shift MSB.
  - READ: `sda_o` ← 1.
- At each S while `bit_cnt` > 0: the register shifts left, inserting `sda_i`, and `bit_cnt` decrements. When it reaches 0, `frame_done_o` pulses on the next cycle.
  - READ: the completed byte is pushed to the RX FIFO. If the FIFO is full, the byte is dropped and `rx_overflow_o` pulses.
- S/D events while `bit_cnt` = 0 are ignored.
- WACK: `sda_o` ← `ack_bit_i` at D.
- RACK: `sda_o` ← 1 at D. At S, `ack_rcvd_o` ← `sda_i` and `ack_valid_o` pulses.
- START: `sda_o` ← 0 at C.
- STOP: `sda_o` ← 0 at D, ← 1 at C.
- RSTART: `sda_o` ← 1 at D, ← 0 at C.
- IDLE: `sda_o` ← 1.
- Arbitration: in ADDR/WRITE, if `sda_o` = 1 and `sda_i` = 0 at S, `arb_lost_o` ← 1.
  - While `arb_lost_o` = 1, `sda_o` is held at 1, though RX sampling continues.
  - `arb_lost_o` is cleared on entry to START.
- Internal FSM: IDLE → SHIFT (frame entry) → DONE (`bit_cnt` = 0) → IDLE or SHIFT on the next `cmd_i` change.
- Reset mid-frame aborts the frame immediately. FIFO contents are discarded.

## Timing
- Reset values:
  - `sda_o` = 1, `ack_rcvd_o` = 1, `tx_ready_o` = 1.
  - All other outputs = 0, `rx_data_o` = 0.
  - Both FIFOs empty.
- `sda_o` changes exactly 1 cycle after the core edge on which the phase equals D or C. It is registered.
- Latency from the last S to `frame_done_o` is 1 cycle. RX push is visible on `rx_valid_o` 1 cycle after S.
- TX push and WRITE-entry pop of an empty FIFO in the same cycle: the pop sees empty, so underrun is reported. There is no bypass.
- RX pop and push on a full FIFO in the same cycle: the pop occurs, the push succeeds and there is no overflow.
- Arithmetic for D/S/C is done in PRESC_W+1 bits. P + P/2 is compared without truncation.

## Structure
- Shared package `i2c_pkg` holds:
  - the `cmd_i` encoding constants (IDLE=0, START=1, ADDR=2, WRITE=3, READ=4, WACK=5, RACK=6, STOP=7, RSTART=8);
  - the internal FSM state encoding;
  - a function computing S from P.
- Sub-module `i2c_sync_fifo` (parameters DATA_W, FIFO_DEPTH) is instantiated twice, once for TX and once for RX. Shift, counter and SDA logic stay in the top.

## Test plan
- P=4, ADDR with `addr_rw_i` = 0xA5: SDA at the 8 D points is 1,0,1,0,0,1,0,1. `frame_done_o` pulses once; `bit_cnt_o` goes 8→0.
- Push 0x3C, 0xFF, then two WRITE frames separated by RACK with `sda_i` = 0: bytes are serialised in order, `ack_rcvd_o` = 0 with 2 `ack_valid_o` pulses, `tx_ready_o` is high throughout.
- READ with `sda_i` pattern 0x96, `rx_ready_i` = 0, repeated 5 times with FIFO_DEPTH=4: 4 bytes of 0x96 are held and one `rx_overflow_o` pulse occurs.
- WRITE with `sda_i` forced 0 at a bit where `sda_o` = 1: `arb_lost_o` = 1 and `sda_o` stays 1 until the next START clears it.
- START, RSTART, STOP sequence: SDA falls at C in START and RSTART, is 1 at D in RSTART, and rises at C in STOP.
- WRITE entry with an empty TX FIFO: `tx_underrun_o` pulses and eight 1s are driven. Reset asserted mid-frame gives `sda_o` = 1 and `bit_cnt_o` = 0 immediately.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared definitions for the burst I2C data path.
// Phase codes, data path FSM states and sample-point arithmetic.
package i2c_pkg;

  localparam logic [3:0] CMD_IDLE   = 4'd0;
  localparam logic [3:0] CMD_START  = 4'd1;
  localparam logic [3:0] CMD_ADDR   = 4'd2;
  localparam logic [3:0] CMD_WRITE  = 4'd3;
  localparam logic [3:0] CMD_READ   = 4'd4;
  localparam logic [3:0] CMD_WACK   = 4'd5;
  localparam logic [3:0] CMD_RACK   = 4'd6;
  localparam logic [3:0] CMD_STOP   = 4'd7;
  localparam logic [3:0] CMD_RSTART = 4'd8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_DONE
  } dp_state_e;

  // P + P/2, one bit wider than P so it never wraps
  function automatic logic [16:0] sample_point(input logic [15:0] p);
    return {1'b0, p} + {2'b00, p[15:1]};
  endfunction

endpackage

// File: rtl/i2c_sync_fifo.sv
// Synchronous FIFO with first-word fall-through read port.
// A pop frees a slot for a push in the same cycle when full.
module i2c_sync_fifo
  import i2c_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              push_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              pop_i,
  output logic              full_o,
  output logic              empty_o,
  output logic [DATA_W-1:0] data_o
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]     wptr_q;
  logic [AW-1:0]     rptr_q;
  logic [AW:0]       cnt_q;
  logic              pop_ok;
  logic              push_ok;

  assign full_o  = (cnt_q == (AW+1)'(FIFO_DEPTH));
  assign empty_o = (cnt_q == '0);
  assign pop_ok  = pop_i && !empty_o;
  assign push_ok = push_i && (!full_o || pop_ok);
  assign data_o  = empty_o ? '0 : mem_q[rptr_q];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_q + AW'(push_ok);
      rptr_q <= rptr_q + AW'(pop_ok);
      cnt_q  <= cnt_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wptr_q] <= data_i;
  end

endmodule

// File: rtl/i2c_data_path_burst.sv
// I2C data path: frame shifter, SDA driver, ACK sampling,
// arbitration detection, with TX/RX burst FIFOs.
module i2c_data_path_burst
  import i2c_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int PRESC_W    = 8
) (
  input  logic                       i2c_core_clock_i,
  input  logic                       reset_bit_i,
  input  logic [PRESC_W-1:0]         prescaler_i,
  input  logic [PRESC_W:0]           counter_detect_edge_i,
  input  logic [3:0]                 cmd_i,
  input  logic                       sda_i,
  input  logic [DATA_W-1:0]          addr_rw_i,
  input  logic                       ack_bit_i,
  input  logic [DATA_W-1:0]          tx_data_i,
  input  logic                       tx_valid_i,
  output logic                       tx_ready_o,
  output logic [DATA_W-1:0]          rx_data_o,
  output logic                       rx_valid_o,
  input  logic                       rx_ready_i,
  output logic                       sda_o,
  output logic [$clog2(DATA_W+1)-1:0] bit_cnt_o,
  output logic                       frame_done_o,
  output logic                       ack_rcvd_o,
  output logic                       ack_valid_o,
  output logic                       arb_lost_o,
  output logic                       tx_underrun_o,
  output logic                       rx_overflow_o
);

  localparam int BW = $clog2(DATA_W+1);
  localparam int CW = PRESC_W + 1;

  dp_state_e         state_q, state_d;
  logic [3:0]        cmd_q;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
  logic              sda_q, sda_d;
  logic              ack_q, ack_d;
  logic              ackv_q, ackv_d;
  logic              arb_q, arb_d;
  logic              done_q, done_d;
  logic              unf_q, unf_d;
  logic              ovf_q, ovf_d;

  logic              tx_full, tx_empty, tx_pop;
  logic [DATA_W-1:0] tx_head;
  logic              rx_full, rx_empty, rx_push, rx_pop_ok;

  logic              d_hit, s_hit, c_hit;
  logic              cmd_chg, is_frame, is_tx, entry, bit_step;
  logic [DATA_W-1:0] shifted;

  assign d_hit    = (counter_detect_edge_i == CW'(1));
  assign s_hit    = (sample_point(16'(prescaler_i))
                     == 17'(counter_detect_edge_i));
  assign c_hit    = s_hit;
  assign cmd_chg  = (cmd_i != cmd_q);
  assign is_tx    = (cmd_i == CMD_ADDR) || (cmd_i == CMD_WRITE);
  assign is_frame = is_tx || (cmd_i == CMD_READ);
  assign entry    = cmd_chg && is_frame;
  assign bit_step = s_hit && is_frame && !entry
                    && (state_q == ST_SHIFT) && (bit_cnt_q != '0);
  assign shifted  = {shift_q[DATA_W-2:0], sda_i};
  assign rx_pop_ok = rx_ready_i && !rx_empty;

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    sda_d     = sda_q;
    ack_d     = ack_q;
    ackv_d    = 1'b0;
    arb_d     = arb_q;
    done_d    = 1'b0;
    unf_d     = 1'b0;
    ovf_d     = 1'b0;
    tx_pop    = 1'b0;
    rx_push   = 1'b0;

    unique case (state_q)
      ST_IDLE:  if (entry) state_d = ST_SHIFT;
      ST_SHIFT: if (entry) state_d = ST_SHIFT;
                else if (bit_cnt_q == '0) state_d = ST_DONE;
      ST_DONE:  if (entry) state_d = ST_SHIFT;
                else if (cmd_chg) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    if (entry) begin
      bit_cnt_d = BW'(DATA_W);
      unique case (1'b1)
        cmd_i == CMD_ADDR:  shift_d = addr_rw_i;
        cmd_i == CMD_WRITE: begin
          tx_pop  = !tx_empty;
          shift_d = tx_empty ? '1 : tx_head;
          unf_d   = tx_empty;
        end
        default:            shift_d = '0;
      endcase
    end else if (bit_step) begin
      shift_d   = shifted;
      bit_cnt_d = bit_cnt_q - BW'(1);
      done_d    = (bit_cnt_q == BW'(1));
      if (is_tx && sda_q && !sda_i) arb_d = 1'b1;
      if (cmd_i == CMD_READ && bit_cnt_q == BW'(1)) begin
        rx_push = 1'b1;
        ovf_d   = rx_full && !rx_pop_ok;
      end
    end

    if (cmd_chg && cmd_i == CMD_START) arb_d = 1'b0;

    unique case (cmd_i)
      CMD_IDLE:   sda_d = 1'b1;
      CMD_START:  if (c_hit) sda_d = 1'b0;
      CMD_ADDR,
      CMD_WRITE:  if (d_hit && bit_cnt_q != '0) sda_d = shift_q[DATA_W-1];
      CMD_READ:   if (d_hit && bit_cnt_q != '0) sda_d = 1'b1;
      CMD_WACK:   if (d_hit) sda_d = ack_bit_i;
      CMD_RACK: begin
        if (d_hit) sda_d = 1'b1;
        if (s_hit) begin
          ack_d  = sda_i;
          ackv_d = 1'b1;
        end
      end
      CMD_STOP:   if (d_hit) sda_d = 1'b0;
                  else if (c_hit) sda_d = 1'b1;
      CMD_RSTART: if (d_hit) sda_d = 1'b1;
                  else if (c_hit) sda_d = 1'b0;
      default:    sda_d = 1'b1;
    endcase

    // a master that lost the bus must only release SDA
    if (arb_d) sda_d = 1'b1;
  end

  always_ff @(posedge i2c_core_clock_i or negedge reset_bit_i) begin
    if (!reset_bit_i) begin
      state_q   <= ST_IDLE;
      cmd_q     <= CMD_IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      sda_q     <= 1'b1;
      ack_q     <= 1'b1;
      ackv_q    <= 1'b0;
      arb_q     <= 1'b0;
      done_q    <= 1'b0;
      unf_q     <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cmd_q     <= cmd_i;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      sda_q     <= sda_d;
      ack_q     <= ack_d;
      ackv_q    <= ackv_d;
      arb_q     <= arb_d;
      done_q    <= done_d;
      unf_q     <= unf_d;
      ovf_q     <= ovf_d;
    end
  end

  i2c_sync_fifo #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_tx_fifo (
    .clk_i   (i2c_core_clock_i),
    .rst_ni  (reset_bit_i),
    .push_i  (tx_valid_i && !tx_full),
    .data_i  (tx_data_i),
    .pop_i   (tx_pop),
    .full_o  (tx_full),
    .empty_o (tx_empty),
    .data_o  (tx_head)
  );

  i2c_sync_fifo #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_rx_fifo (
    .clk_i   (i2c_core_clock_i),
    .rst_ni  (reset_bit_i),
    .push_i  (rx_push),
    .data_i  (shifted),
    .pop_i   (rx_ready_i),
    .full_o  (rx_full),
    .empty_o (rx_empty),
    .data_o  (rx_data_o)
  );

  assign tx_ready_o    = !tx_full;
  assign rx_valid_o    = !rx_empty;
  assign sda_o         = sda_q;
  assign bit_cnt_o     = bit_cnt_q;
  assign frame_done_o  = done_q;
  assign ack_rcvd_o    = ack_q;
  assign ack_valid_o   = ackv_q;
  assign arb_lost_o    = arb_q;
  assign tx_underrun_o = unf_q;
  assign rx_overflow_o = ovf_q;

endmodule

// File: tb/tb_i2c_data_path_burst.sv
// Randomised bench for i2c_data_path_burst with a bit-level bus
// model: SDA is the wired-AND of the DUT drive and a remote driver.
module tb_i2c_data_path_burst;

  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int PW    = 8;
  localparam int CW    = PW + 1;

  localparam logic [3:0] C_IDLE   = 4'd0;
  localparam logic [3:0] C_START  = 4'd1;
  localparam logic [3:0] C_ADDR   = 4'd2;
  localparam logic [3:0] C_WRITE  = 4'd3;
  localparam logic [3:0] C_READ   = 4'd4;
  localparam logic [3:0] C_WACK   = 4'd5;
  localparam logic [3:0] C_RACK   = 4'd6;
  localparam logic [3:0] C_STOP   = 4'd7;
  localparam logic [3:0] C_RSTART = 4'd8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [PW-1:0] presc = PW'(4);
  logic [CW-1:0] cnt = '0;
  logic [3:0]    cmd = C_IDLE;
  logic          sda_in = 1'b1;
  logic [DW-1:0] addr = '0;
  logic          ackb = 1'b0;
  logic [DW-1:0] txd = '0;
  logic          txv = 1'b0;
  logic          rx_rdy = 1'b0;

  logic          txr;
  logic [DW-1:0] rx_data;
  logic          rxv;
  logic          sda_o;
  logic [3:0]    bit_cnt;
  logic          frame_done, ack_rcvd, ack_valid, arb_lost, unf, ovf;

  i2c_data_path_burst #(
    .DATA_W (DW), .FIFO_DEPTH (DEPTH), .PRESC_W (PW)
  ) dut (
    .i2c_core_clock_i      (clk),
    .reset_bit_i           (rst_n),
    .prescaler_i           (presc),
    .counter_detect_edge_i (cnt),
    .cmd_i                 (cmd),
    .sda_i                 (sda_in),
    .addr_rw_i             (addr),
    .ack_bit_i             (ackb),
    .tx_data_i             (txd),
    .tx_valid_i            (txv),
    .tx_ready_o            (txr),
    .rx_data_o             (rx_data),
    .rx_valid_o            (rxv),
    .rx_ready_i            (rx_rdy),
    .sda_o                 (sda_o),
    .bit_cnt_o             (bit_cnt),
    .frame_done_o          (frame_done),
    .ack_rcvd_o            (ack_rcvd),
    .ack_valid_o           (ack_valid),
    .arb_lost_o            (arb_lost),
    .tx_underrun_o         (unf),
    .rx_overflow_o         (ovf)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int P, spt;
  int done_n, ackv_n, ovf_n, unf_n, bc_first;
  logic dq[$];
  logic cq[$];
  logic [DW-1:0] popped;
  logic popped_v;

  task automatic clr();
    done_n = 0; ackv_n = 0; ovf_n = 0; unf_n = 0;
    dq.delete(); cq.delete();
  endtask

  task automatic setp(input int p);
    P = p; spt = p + p / 2; presc = PW'(p);
  endtask

  function automatic logic [DW-1:0] dq_byte();
    logic [DW-1:0] r = '0;
    for (int i = 0; i < DW && i < dq.size(); i++) r[DW-1-i] = dq[i];
    return r;
  endfunction

  // n bit periods of the current cmd; remote driver bit = ext MSB-first
  task automatic run_bits(input int n, input logic [7:0] ext,
                          input bit pop_last);
    for (int b = 0; b < n; b++) begin
      for (int ph = 0; ph < 2 * P; ph++) begin
        cnt = CW'(ph);
        sda_in = sda_o & ext[7-b];
        if (pop_last && b == n - 1 && ph == spt) begin
          rx_rdy = 1'b1; popped = rx_data; popped_v = rxv;
        end
        @(posedge clk); #1;
        rx_rdy = 1'b0;
        txv = 1'b0;
        if (frame_done) done_n++;
        if (ack_valid) ackv_n++;
        if (ovf) ovf_n++;
        if (unf) unf_n++;
        if (b == 0 && ph == 0) bc_first = int'(bit_cnt);
        if (ph == 1) dq.push_back(sda_o);
        if (ph == spt) cq.push_back(sda_o);
      end
    end
  endtask

  task automatic frame(input logic [3:0] c, input logic [7:0] ext,
                       input bit pop_last);
    cmd = c;
    run_bits(8, ext, pop_last);
  endtask

  task automatic period(input logic [3:0] c, input logic [7:0] ext);
    cmd = c;
    run_bits(1, ext, 1'b0);
  endtask

  task automatic tx_push(input logic [DW-1:0] v);
    txd = v; txv = 1'b1;
    @(posedge clk); #1;
    txv = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if (sda_o !== 1'b1 || ack_rcvd !== 1'b1 || txr !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_high sda=%b ack=%b txr=%b want 1 1 1",
               sda_o, ack_rcvd, txr);
    end
    n_tests++;
    if (rxv !== 1'b0 || rx_data !== 8'h00 || bit_cnt !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_low rxv=%b rxd=%h bc=%0d want 0 00 0",
               rxv, rx_data, bit_cnt);
    end
    n_tests++;
    if ({frame_done, ack_valid, arb_lost, unf, ovf} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_pulses got %b want 00000",
               {frame_done, ack_valid, arb_lost, unf, ovf});
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_addr();
    logic [DW-1:0] v;
    setp(4);
    for (int it = 0; it < 2; it++) begin
      v = (it == 0) ? 8'hA5 : DW'($urandom);
      addr = v;
      clr();
      frame(C_ADDR, 8'hFF, 1'b0);
      n_tests++;
      if (dq_byte() !== v) begin
        n_fail++;
        $display("FAIL addr_bits got %h want %h", dq_byte(), v);
      end
      n_tests++;
      if (done_n != 1 || bc_first != 8 || bit_cnt !== 4'd0) begin
        n_fail++;
        $display("FAIL addr_frame done=%0d bc0=%0d bc=%0d want 1 8 0",
                 done_n, bc_first, bit_cnt);
      end
      period(C_IDLE, 8'hFF);
    end
  endtask

  task automatic test_write_burst();
    logic [DW-1:0] txq[$];
    int n;
    setp($urandom_range(4, 9));
    n = $urandom_range(2, 3);
    for (int i = 0; i < n; i++) begin
      n_tests++;
      if (txr !== (txq.size() < DEPTH)) begin
        n_fail++;
        $display("FAIL tx_ready got %b want %b", txr, txq.size() < DEPTH);
      end
      txq.push_back(DW'($urandom));
      tx_push(txq[i]);
    end
    clr();
    for (int i = 0; i < n; i++) begin
      dq.delete();
      frame(C_WRITE, 8'hFF, 1'b0);
      n_tests++;
      if (dq_byte() !== txq[i]) begin
        n_fail++;
        $display("FAIL write_bits[%0d] got %h want %h", i, dq_byte(), txq[i]);
      end
      period(C_RACK, 8'h00);
      n_tests++;
      if (ack_rcvd !== 1'b0) begin
        n_fail++;
        $display("FAIL rack_ack got %b want 0", ack_rcvd);
      end
    end
    n_tests++;
    if (ackv_n != n || done_n != n || unf_n != 0 || txr !== 1'b1) begin
      n_fail++;
      $display("FAIL write_burst ackv=%0d done=%0d unf=%0d txr=%b want %0d %0d 0 1",
               ackv_n, done_n, unf_n, txr, n, n);
    end
    period(C_IDLE, 8'hFF);
  endtask

  task automatic drain(input string nm, inout logic [DW-1:0] q[$]);
    for (int i = 0; i < DEPTH + 2 && rxv === 1'b1; i++) begin
      n_tests++;
      if (q.size() == 0) begin
        n_fail++;
        $display("FAIL %s_extra got %h want none", nm, rx_data);
      end else if (rx_data !== q[0]) begin
        n_fail++;
        $display("FAIL %s_data got %h want %h", nm, rx_data, q[0]);
      end
      if (q.size() != 0) void'(q.pop_front());
      rx_rdy = 1'b1;
      @(posedge clk); #1;
      rx_rdy = 1'b0;
    end
    n_tests++;
    if (q.size() != 0 || rxv !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_left got %0d rxv=%b want 0 0", nm, q.size(), rxv);
    end
  endtask

  task automatic test_read_overflow();
    logic [DW-1:0] rxq[$];
    logic [DW-1:0] v;
    int exp_ovf = 0;
    setp($urandom_range(4, 9));
    ackb = 1'b0;
    clr();
    for (int f = 0; f < 5; f++) begin
      v = (f == 0) ? 8'h96 : DW'($urandom);
      frame(C_READ, v, 1'b0);
      if (rxq.size() < DEPTH) rxq.push_back(v);
      else exp_ovf++;
      period(C_WACK, 8'hFF);
    end
    n_tests++;
    if (ovf_n != exp_ovf || done_n != 5) begin
      n_fail++;
      $display("FAIL rx_overflow ovf=%0d done=%0d want %0d 5",
               ovf_n, done_n, exp_ovf);
    end
    drain("rx_ovf", rxq);
    period(C_IDLE, 8'hFF);
  endtask

  task automatic test_rx_full_pop_push();
    logic [DW-1:0] rxq[$];
    logic [DW-1:0] v, exp_pop;
    setp($urandom_range(4, 9));
    clr();
    for (int f = 0; f < DEPTH + 1; f++) begin
      v = DW'($urandom);
      frame(C_READ, v, f == DEPTH);
      if (f == DEPTH) begin
        exp_pop = rxq.pop_front();
        n_tests++;
        if (popped_v !== 1'b1 || popped !== exp_pop) begin
          n_fail++;
          $display("FAIL rx_pop_push got %b/%h want 1/%h",
                   popped_v, popped, exp_pop);
        end
      end
      rxq.push_back(v);
      period(C_WACK, 8'hFF);
    end
    n_tests++;
    if (ovf_n != 0) begin
      n_fail++;
      $display("FAIL rx_pop_push_ovf got %0d want 0", ovf_n);
    end
    drain("rx_pp", rxq);
    period(C_IDLE, 8'hFF);
  endtask

  task automatic test_arb();
    logic [DW-1:0] v, ext, exp;
    int k;
    setp($urandom_range(4, 9));
    v = DW'($urandom_range(1, 255));
    k = 0;
    while (v[7-k] == 1'b0) k++;
    ext = 8'hFF;
    ext[7-k] = 1'b0;
    for (int i = 0; i < 8; i++) exp[7-i] = (i <= k) ? v[7-i] : 1'b1;
    tx_push(v);
    clr();
    frame(C_WRITE, ext, 1'b0);
    n_tests++;
    if (dq_byte() !== exp || arb_lost !== 1'b1) begin
      n_fail++;
      $display("FAIL arb_write bits=%h arb=%b want %h 1",
               dq_byte(), arb_lost, exp);
    end
    period(C_IDLE, 8'hFF);
    n_tests++;
    if (arb_lost !== 1'b1 || sda_o !== 1'b1) begin
      n_fail++;
      $display("FAIL arb_sticky arb=%b sda=%b want 1 1", arb_lost, sda_o);
    end
    clr();
    period(C_START, 8'hFF);
    n_tests++;
    if (arb_lost !== 1'b0 || cq[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL arb_clear arb=%b sdaC=%b want 0 0", arb_lost, cq[0]);
    end
    period(C_IDLE, 8'hFF);
  endtask

  task automatic test_conditions();
    logic [3:0] seq [3];
    logic [1:0] want [3];
    seq[0] = C_START;  want[0] = 2'b10;
    seq[1] = C_RSTART; want[1] = 2'b10;
    seq[2] = C_STOP;   want[2] = 2'b01;
    setp($urandom_range(4, 9));
    period(C_IDLE, 8'hFF);
    for (int i = 0; i < 3; i++) begin
      clr();
      period(seq[i], 8'hFF);
      n_tests++;
      if ({dq[0], cq[0]} !== want[i]) begin
        n_fail++;
        $display("FAIL cond_%0d D/C got %b want %b", seq[i],
                 {dq[0], cq[0]}, want[i]);
      end
    end
    period(C_IDLE, 8'hFF);
  endtask

  task automatic test_underrun();
    logic [DW-1:0] w;
    setp($urandom_range(4, 9));
    w = DW'($urandom);
    txd = w; txv = 1'b1;
    clr();
    frame(C_WRITE, 8'hFF, 1'b0);
    n_tests++;
    if (unf_n != 1 || dq_byte() !== 8'hFF || done_n != 1) begin
      n_fail++;
      $display("FAIL underrun unf=%0d bits=%h done=%0d want 1 ff 1",
               unf_n, dq_byte(), done_n);
    end
    period(C_RACK, 8'hFF);
    dq.delete();
    frame(C_WRITE, 8'hFF, 1'b0);
    n_tests++;
    if (dq_byte() !== w || unf_n != 1) begin
      n_fail++;
      $display("FAIL underrun_push bits=%h unf=%0d want %h 1",
               dq_byte(), unf_n, w);
    end
    period(C_IDLE, 8'hFF);
  endtask

  task automatic test_reset_mid();
    setp($urandom_range(4, 9));
    tx_push(DW'($urandom));
    addr = 8'h00;
    cmd = C_ADDR;
    run_bits(3, 8'hFF, 1'b0);
    n_tests++;
    if (sda_o !== 1'b0 || bit_cnt !== 4'd5) begin
      n_fail++;
      $display("FAIL mid_pre sda=%b bc=%0d want 0 5", sda_o, bit_cnt);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (sda_o !== 1'b1 || bit_cnt !== 4'd0) begin
      n_fail++;
      $display("FAIL mid_reset sda=%b bc=%0d want 1 0", sda_o, bit_cnt);
    end
    cmd = C_IDLE;
    @(posedge clk); #1;
    rst_n = 1'b1;
    period(C_IDLE, 8'hFF);
    clr();
    frame(C_WRITE, 8'hFF, 1'b0);
    n_tests++;
    if (unf_n != 1 || dq_byte() !== 8'hFF) begin
      n_fail++;
      $display("FAIL mid_flush unf=%0d bits=%h want 1 ff", unf_n, dq_byte());
    end
    period(C_IDLE, 8'hFF);
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    setp(4);
    test_reset();
    test_addr();
    test_write_burst();
    test_read_overflow();
    test_rx_full_pop_push();
    test_arb();
    test_conditions();
    test_underrun();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
